ram_task2: RTL and testbench
============================

Name: ram_task2

Overview:
- Single-port 512 x 20-bit backing RAM for the L1 cache.
- Each entry holds one cache block of two 10-bit words.
- Shared bidirectional 20-bit data bus; request/ready handshake with fixed, parameterised latency.
- Sits below the cache controller, which issues block reads (allocation) and block writes (write-back).

Parameters:
- LATENCY, 1: BUSY cycles between request acceptance and mem_ready; legal range 1..15.
- DEPTH, 512: number of 20-bit blocks; equals 2^(address width - 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- mem_req  input  1  request strobe from the cache.
- we  input  1  1 = block write, 0 = block read; sampled with mem_req.
- address  input  10  word address.
  - address[9:1] selects the block.
  - address[0] is ignored (whole block transferred).
- data  inout  20  block data bus.
  - Driven by this block only during a read response; otherwise high-Z.
- mem_ready  output  1  one-cycle completion pulse for reads and writes.

Behaviour:
- Storage: mem[0..DEPTH-1], 20 bits each. Preloaded at time zero so block b = {word 2b+1, word 2b}: every 10-bit word holds its own word address (block 25 = {10'd51, 10'd50}).
- Reset does not alter contents.
- FSM states: IDLE, BUSY, RESP; reset state IDLE.
- Reset values: mem_ready=0, data high-Z, internal latches cleared.
- IDLE:
  - Rising edge with mem_req=1 accepts the request.
  - Latches address[9:1] and we, loads latency counter with LATENCY, goes to BUSY.
  - If we=1, data is sampled on that same edge and written to mem[address[9:1]] on that edge (write committed at acceptance).
  - With mem_req=0, stays in IDLE.
- BUSY:
  - Counter decrements each edge; goes to RESP on the edge where the counter reaches 1.
  - LATENCY=1 means exactly one BUSY cycle.
  - mem_req, we, address and data are ignored.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - If the latched we=0, data drives mem[latched block] for this cycle; otherwise data stays high-Z.
  - Next edge always returns to IDLE; mem_req is not sampled on that edge.
- Timing: request accepted at edge k; mem_ready high from edge k+LATENCY to edge k+LATENCY+1.
  - Earliest next acceptance: edge k+LATENCY+2.
  - A held mem_req therefore restarts a new transaction.
- Read data comes from the array at RESP time, so a read accepted after a write to the same block returns the new data.
- mem_ready is registered (no combinational path from inputs).
- data is never driven while we=1 is latched, which avoids contention with the writer.
- Asserting rst in BUSY or RESP aborts immediately:
  - State goes to IDLE, mem_ready=0, data released.
  - A write already committed at acceptance stays committed.
- Address wrap: none needed; all 512 blocks are addressable.
- Out-of-range LATENCY (0 or >15) is a configuration error flagged at elaboration.

Optional Feature:
- Macro RAM_TRACE_EN.
- Defined: on every accepted request, the simulation prints time, R/W, block index and data (write data, or read data at RESP). No effect on RTL behaviour or timing.
- Undefined: no trace code compiled; behaviour identical.

Test Plan:
- Reset, then read: rst=1 for 1 cycle, mem_req=1, we=0, address=50 for one edge.
  - mem_ready pulses LATENCY cycles later for one cycle.
  - data = {10'd51, 10'd50} during the pulse, high-Z before and after.
- Write then read back: write address=84 (block 42) with data=20'h12C2C, then read address=85.
  - Read returns 20'h12C2C; a write's mem_ready pulse leaves data high-Z.
- Held request: mem_req kept high with we=0, address=10.
  - mem_ready pulses every LATENCY+2 cycles.
  - Each pulse presents {10'd11, 10'd10}.
- Ignore during BUSY: accept a read of block 5, then change address/we/mem_req during BUSY.
  - Response still returns block 5; no write occurs.
- Reset mid-op: assert rst during BUSY of a read.
  - mem_ready never pulses, data stays high-Z.
  - A subsequent read completes normally.
- LATENCY=3 build: the read of address 0 shows mem_ready exactly 3 edges after acceptance, with data={10'd1, 10'd0}.

Source files
------------

// File: rtl/ram_task2_if.sv
// Request/ready handshake between the L1 cache controller (master) and its
// backing RAM (slave). The shared block data bus is carried as a separate inout.
interface ram_task2_if;
  logic       mem_req;
  logic       we;
  logic [9:0] address;
  logic       mem_ready;

  modport master (
    output mem_req,
    output we,
    output address,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  we,
    input  address,
    output mem_ready
  );
endinterface

// File: rtl/ram_task2.sv
// 512 x 20-bit single-port block RAM behind the L1 cache, fixed-latency req/ready.
// Optional RAM_TRACE_EN: prints each accepted access (simulation only).
module ram_task2 #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 512
) (
  input  logic             clk,
  input  logic             rst,
  ram_task2_if.slave       bus,
  inout  wire [19:0]       data
);
  localparam int BLK_W = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ram_task2: LATENCY %0d outside 1..15", LATENCY);
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef logic [DEPTH-1:0][19:0] mem_t;

  // Power-up image: every 10-bit word holds its own word address.
  function automatic mem_t preload();
    mem_t m;
    for (int b = 0; b < DEPTH; b++) begin
      m[b] = {10'(2 * b + 1), 10'(2 * b)};
    end
    return m;
  endfunction

  mem_t             mem_q = preload();
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             we_q, we_d;
  logic             ready_q;
  logic             oe_q;
  logic             accept;
  logic             unused_addr0;

  assign unused_addr0 = bus.address[0];
  assign accept       = (state_q == IDLE) && bus.mem_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY);
          blk_d   = bus.address[BLK_W:1];
          we_d    = bus.we;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready and bus enable are registered off the next state, so both line up with RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      blk_q   <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      we_q    <= we_d;
      ready_q <= (state_d == RESP);
      oe_q    <= (state_d == RESP) && !we_d;
    end
  end

  // Writes commit on the accepting edge; reset never touches the array.
  always_ff @(posedge clk) begin
    if (accept && bus.we && !rst) begin
      mem_q[bus.address[BLK_W:1]] <= data;
    end
  end

  assign bus.mem_ready = ready_q;
  assign data          = oe_q ? mem_q[blk_q] : 20'bz;

`ifdef RAM_TRACE_EN
  always @(posedge clk) begin
    if (accept && bus.we && !rst)
      $display("[ram_task2] %0t W blk %0d data %h", $time, bus.address[BLK_W:1], data);
    if (state_q == RESP && !we_q && !rst)
      $display("[ram_task2] %0t R blk %0d data %h", $time, blk_q, mem_q[blk_q]);
  end
`endif
endmodule

// File: tb/tb_ram_task2.sv
// Scoreboard bench for ram_task2: transaction-level reference model feeds an
// expectation queue that a negedge monitor drains against mem_ready/data.
module tb_ram_task2;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ram_task2_if bus0();
  ram_task2_if bus3();
  wire  [19:0] data0;
  wire  [19:0] data3;

  logic        tb_en  = 1'b1;
  logic [19:0] tb_val = 20'h0;
  assign data0 = tb_en ? tb_val : 20'bz;

  ram_task2 #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk (clk), .rst (rst), .bus (bus0), .data (data0)
  );
  ram_task2 #(.LATENCY(3), .DEPTH(512)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3), .data (data3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ed;
    bit          rd;
    logic [19:0] d;
  } exp_t;

  exp_t        q[$];
  logic [19:0] ref_mem [512];
  int          next_free = 0;
  bit          rd_pend   = 0;
  int          rd_end    = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus, called just after an edge; the model decides acceptance.
  task automatic step(input bit req, input bit wr, input logic [9:0] addr, input logic [19:0] wd);
    int   e;
    exp_t x;
    e = cyc + 1;
    if (rd_pend && cyc >= rd_end) rd_pend = 0;
    bus0.mem_req = req;
    bus0.we      = wr;
    bus0.address = addr;
    tb_val       = wd;
    tb_en        = !rd_pend;
    if (req && e >= next_free) begin
      x.ed = e + LAT;
      x.rd = !wr;
      if (wr) begin
        ref_mem[addr[9:1]] = wd;
        x.d = 20'h0;
      end else begin
        x.d     = ref_mem[addr[9:1]];
        rd_pend = 1;
        rd_end  = e + LAT + 1;
      end
      q.push_back(x);
      next_free = e + LAT + 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus0.mem_req = 1'b0;
    q.delete();
    rd_pend = 0;
    tb_val  = 20'h0;
    tb_en   = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    next_free = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 20'h0);
  endtask

  // Monitor: every negedge, match mem_ready/data against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus0.mem_ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("ready_edge", cyc, x.ed);
          if (x.rd) check("rd_data", {12'h0, data0}, {12'h0, x.d});
          else      check("wr_resp_bus", {12'h0, data0}, {12'h0, tb_val});
        end
      end else begin
        if (q.size() != 0 && q[0].ed <= cyc) begin
          check("missing_ready", 32'd0, 32'd1);
          void'(q.pop_front());
        end
        if (tb_en) check("bus_released", {12'h0, data0}, {12'h0, tb_val});
      end
    end
  end

  initial begin
    int          got;
    int          ea;
    logic [19:0] d3;

    for (int b = 0; b < 512; b++) ref_mem[b] = {10'(2 * b + 1), 10'(2 * b)};
    bus0.mem_req = 1'b0; bus0.we = 1'b0; bus0.address = 10'd0;
    bus3.mem_req = 1'b0; bus3.we = 1'b0; bus3.address = 10'd0;

    // Reset for one cycle, then read word address 50.
    @(posedge clk);
    #1;
    check("reset_ready", {31'h0, bus0.mem_ready}, 32'd0);
    rst       = 1'b0;
    next_free = cyc + 1;
    step(1'b1, 1'b0, 10'd50, 20'h0);
    idle(LAT + 2);

    // Write block 42, read it back through the other word address.
    step(1'b1, 1'b1, 10'd84, 20'h12C2C);
    idle(LAT + 1);
    step(1'b1, 1'b0, 10'd85, 20'h0);
    idle(LAT + 2);

    // Held read request restarts every LAT+2 cycles.
    for (int i = 0; i < 4 * (LAT + 2); i++) step(1'b1, 1'b0, 10'd10, 20'($urandom));
    idle(LAT + 2);

    // Inputs change while busy: only the block 5 read takes effect.
    step(1'b1, 1'b0, 10'd11, 20'h0);
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 10'd11, 20'hABCDE);
    idle(LAT + 2);
    step(1'b1, 1'b0, 10'd10, 20'h0);
    idle(LAT + 2);

    // Abort a read while busy, then read normally.
    step(1'b1, 1'b0, 10'd40, 20'h0);
    do_reset();
    idle(LAT + 3);
    step(1'b1, 1'b0, 10'd40, 20'h0);
    idle(LAT + 2);

    // Randomised traffic over a few hot blocks plus the full range.
    for (int i = 0; i < 400; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, 20'($urandom));
    end
    idle(LAT + 3);

    // LATENCY=3 instance: read address 0.
    bus3.mem_req = 1'b1; bus3.we = 1'b0; bus3.address = 10'd0;
    ea = cyc + 1;
    @(posedge clk);
    #1;
    bus3.mem_req = 1'b0;
    got = 0;
    d3  = 20'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus3.mem_ready) begin
        got = cyc;
        d3  = data3;
        break;
      end
    end
    check("lat3_edge", got, ea + 3);
    check("lat3_data", {12'h0, d3}, {12'h0, 10'd1, 10'd0});
    @(negedge clk);
    check("lat3_pulse_width", {31'h0, bus3.mem_ready}, 32'd0);

    @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
